// File: rtl/signed_accum_sat_if.sv
// Valid/ready stream bundle for the signed frame accumulator.
// Operand side and result side travel together.
interface signed_accum_sat_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             sat_mode;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_overflow;
    logic [CNT_W-1:0] out_count;

    modport master (
        output sat_mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow, out_count
    );

    modport slave (
        input  sat_mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_overflow, out_count
    );
endinterface

// File: rtl/signed_accum_sat.sv
// Frame-based signed accumulator with per-step overflow detection and
// selectable wrap or saturate arithmetic; one-entry result hold stage.
module signed_accum_sat #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    signed_accum_sat_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_t           state, state_nx;
    logic [W-1:0]     acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     sum_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic [W-1:0]     s;
    logic             v;
    logic [W-1:0]     step_val;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nx = ACCUM;
            end
            default: state_nx = ACCUM;
        endcase
    end

    // Overflow only possible when operands share a sign and the sum flips it.
    always_comb begin
        accept   = bus.in_valid && in_ready;
        s        = acc + bus.in_data;
        v        = (acc[W-1] == bus.in_data[W-1]) && (s[W-1] != acc[W-1]);
        step_val = s;
        if (v && bus.sat_mode) step_val = acc[W-1] ? MIN_NEG : MAX_POS;
        cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            if (bus.in_last) begin
                sum_q <= step_val;
                ovf_q <= ovf | v;
                cnt_q <= cnt_inc;
                acc   <= '0;
                ovf   <= 1'b0;
                cnt   <= '0;
            end else begin
                acc   <= step_val;
                ovf   <= ovf | v;
                cnt   <= cnt_inc;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_sum      = sum_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_count    = cnt_q;
endmodule

// File: tb/tb_signed_accum_sat.sv
// Directed bench for signed_accum_sat with W=4, CNT_W=8.
module tb_signed_accum_sat;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    signed_accum_sat_if #(.W(4), .CNT_W(8)) bus ();

    signed_accum_sat #(.W(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic last, input logic mode);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.sat_mode = mode;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic expect_result(input string tag, input logic [3:0] sum,
                                 input logic ovf, input logic [7:0] cnt);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_sum"},   32'(bus.out_sum), 32'(sum));
        check({tag, "_ovf"},   32'(bus.out_overflow), 32'(ovf));
        check({tag, "_cnt"},   32'(bus.out_count), 32'(cnt));
        check({tag, "_inrdy"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.sat_mode  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",   32'(bus.out_sum), 32'd0);
        check("rst_ovf",   32'(bus.out_overflow), 32'd0);
        check("rst_cnt",   32'(bus.out_count), 32'd0);
        check("rst_inrdy", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // wrap: 7 + 1 -> -8
        send(4'd7, 1'b0, 1'b0);
        check("wrap_midvalid", 32'(bus.out_valid), 32'd0);
        send(4'd1, 1'b1, 1'b0);
        expect_result("wrap", 4'b1000, 1'b1, 8'd2);
        take_result();
        check("wrap_after_valid", 32'(bus.out_valid), 32'd0);
        check("wrap_after_inrdy", 32'(bus.in_ready), 32'd1);

        // saturate high: 7 + 1 -> 7
        send(4'd7, 1'b0, 1'b1);
        send(4'd1, 1'b1, 1'b1);
        expect_result("sat_hi", 4'd7, 1'b1, 8'd2);
        take_result();

        // saturate low: -8 + -1 -> -8
        send(4'b1000, 1'b0, 1'b1);
        send(4'b1111, 1'b1, 1'b1);
        expect_result("sat_lo", 4'b1000, 1'b1, 8'd2);
        take_result();

        // saturation is not sticky on the value: 5+5 -> 7, 7-7 -> 0
        send(4'd5, 1'b0, 1'b1);
        send(4'd5, 1'b0, 1'b1);
        send(4'b1001, 1'b1, 1'b1);
        expect_result("sat_resume", 4'd0, 1'b1, 8'd3);
        take_result();

        // no overflow, then backpressure with ignored input pulses
        send(4'd3, 1'b0, 1'b0);
        send(4'b1110, 1'b0, 1'b0);
        send(4'd4, 1'b1, 1'b0);
        expect_result("plain", 4'd5, 1'b0, 8'd3);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'd7;
            bus.in_last  = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            expect_result("hold", 4'd5, 1'b0, 8'd3);
        end
        bus.in_last = 1'b0;
        take_result();

        // wrap that returns into range still flags overflow: 7+1-1
        send(4'd7, 1'b0, 1'b0);
        send(4'd1, 1'b0, 1'b0);
        send(4'b1111, 1'b1, 1'b0);
        expect_result("wrap_back", 4'd7, 1'b1, 8'd3);
        take_result();

        // back-to-back frames with out_ready held high: one bubble
        bus.out_ready = 1'b1;
        send(4'b1101, 1'b1, 1'b0);
        expect_result("b2b_a", 4'b1101, 1'b0, 8'd1);
        @(posedge clk); #1;
        check("bubble_valid", 32'(bus.out_valid), 32'd0);
        check("bubble_inrdy", 32'(bus.in_ready), 32'd1);
        send(4'd2, 1'b0, 1'b0);
        send(4'd2, 1'b1, 1'b0);
        expect_result("b2b_b", 4'd4, 1'b0, 8'd2);
        @(posedge clk); #1;
        check("b2b_b_after", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // counter saturates at 255 on a 260-operand frame
        for (int i = 0; i < 259; i++) send(4'd0, 1'b0, 1'b0);
        send(4'd0, 1'b1, 1'b0);
        expect_result("cnt_sat", 4'd0, 1'b0, 8'd255);
        take_result();

        // reset mid-frame discards the partial frame
        send(4'd3, 1'b0, 1'b0);
        send(4'd2, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_sum",   32'(bus.out_sum), 32'd0);
        check("mrst_ovf",   32'(bus.out_overflow), 32'd0);
        check("mrst_cnt",   32'(bus.out_count), 32'd0);
        check("mrst_inrdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send(4'd1, 1'b1, 1'b0);
        expect_result("post_rst", 4'd1, 1'b0, 8'd1);
        take_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/signed_accum_sat.md
Name: signed_accum_sat

Overview:
- Streaming signed (two's complement) accumulator that sums a frame of W-bit operands into a W-bit result.
- Overflow detection per addition, with either wrap-around or saturating arithmetic selected by a mode input.
- Sits in the arithmetic datapath as the sequential, frame-based, parametrised successor of the 4-bit signed adder-with-overflow.
- Valid/ready handshake on input and output.

Parameters:
- W, 4, operand and result width in bits (W >= 2).
- CNT_W, 8, width of the frame operand counter; the counter saturates at 2**CNT_W-1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sat_mode  input  1  1 = saturate on overflow, 0 = wrap (modulo 2**W); sampled on each accepted operand.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  W  signed operand.
- in_last  input  1  operand is the last of its frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  W  signed frame result.
- out_overflow  output  1  sticky: at least one addition in the frame overflowed.
- out_count  output  CNT_W  number of operands in the frame, saturating.

Behaviour:
- Reset (async assert, sync release):
  - state = ACCUM; acc = 0; ovf = 0; cnt = 0.
  - out_valid = 0, out_sum = 0, out_overflow = 0, out_count = 0, in_ready = 1.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Transfers occur only when valid && ready on the same edge.
- Step arithmetic on an accepted operand d:
  - s = acc + d, truncated to W bits.
  - Step overflow v = (acc[W-1] == d[W-1]) && (s[W-1] != acc[W-1]).
  - new = v && sat_mode ? (acc[W-1] ? -2**(W-1) : 2**(W-1)-1) : s.
  - Following steps continue from new; saturation is not sticky on the value, only on the flag.
- ACCUM, accepted operand with in_last = 0:
  - acc <= new; ovf <= ovf | v; cnt <= min(cnt+1, 2**CNT_W-1).
- ACCUM, accepted operand with in_last = 1:
  - out_sum <= new, out_overflow <= ovf | v, out_count <= min(cnt+1, max).
  - acc, ovf, cnt cleared to 0; state -> HOLD.
  - out_valid is high the cycle after the last operand is accepted (latency 1).
- HOLD:
  - out_sum, out_overflow and out_count are stable while out_valid && !out_ready.
  - On out_ready, state -> ACCUM; in_ready returns to 1 the next cycle. There is no same-cycle bypass (bubble of 1 cycle per frame).
- Single-operand frame (in_last on the first operand): out_sum = d, out_overflow = 0, out_count = 1.
- in_data, in_last and sat_mode are ignored when in_valid = 0 or in_ready = 0.
- Asserting rst_n low mid-frame or in HOLD discards the partial frame and the pending result; no output is produced for it.
- Overflow flag semantics are per step. A wrapped sequence that returns in range (e.g. 7+1-1 with W=4) still reports out_overflow = 1.

Test Plan:
- W=4, wrap, frame {7, 1 last} -> out_sum = -8 (4'b1000), out_overflow = 1, out_count = 2, out_valid 1 cycle after last.
- W=4, sat, frame {7, 1 last} -> out_sum = 7, overflow = 1.
- W=4, sat, frame {-8, -1 last} -> out_sum = -8, overflow = 1.
- W=4, sat, frame {5, 5, -7 last} -> 7 then 0, out_sum = 0, overflow = 1.
- W=4, frame {3, -2, 4 last} -> out_sum = 5, overflow = 0, count = 3. Hold out_ready = 0 for 5 cycles: outputs stable, in_ready = 0, in_valid pulses ignored.
- Back-to-back frames {-3 last} then {2, 2 last} with out_ready = 1 -> results -3/0/1 then 4/0/2, one bubble between frames.
- Reset pulse after 2 operands of a frame -> all outputs 0, in_ready = 1. Next frame {1 last} -> out_sum = 1, count = 1.
